// File: rtl/sound_event_sequencer_if.sv
//==============================================================================
// Module      : sound_event_sequencer_if
// Description : Event handshake and player-control bundle for the sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sound_event_sequencer_if #(
  parameter int unsigned QDEPTH = 4
) ();
  logic                      event_valid;
  logic [2:0]                event_id;
  logic                      event_ready;
  logic                      stop;
  logic                      play;
  logic [2:0]                soundchoice;
  logic                      busy;
  logic [$clog2(QDEPTH):0]   queue_count;
  logic                      bad_event;

  modport master (
    output event_valid, event_id, stop,
    input  event_ready, play, soundchoice, busy, queue_count, bad_event
  );

  modport slave (
    input  event_valid, event_id, stop,
    output event_ready, play, soundchoice, busy, queue_count, bad_event
  );
endinterface

`default_nettype wire

// File: rtl/sound_event_sequencer.sv
//==============================================================================
// Module      : sound_event_sequencer
// Description : Queues game sound events and times each clip for the PWM player.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sound_event_sequencer #(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned LEN_CHOMP = 49_001_706,
  parameter int unsigned LEN_PLACE = 75_486_829,
  parameter int unsigned LEN_TRAV  = 197_955_648,
  parameter int unsigned LEN_MOVE  = 96_007_023,
  parameter int unsigned LEN_OVER  = 321_007_180
) (
  input  wire logic              clk,
  input  wire logic              rst,
  sound_event_sequencer_if.slave bus
);

  localparam int                 c_ptr_w = $clog2(QDEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(QDEPTH);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PLAYING = 1'b1
  } state_t;

  state_t               r_state;
  logic [2:0]           r_mem [QDEPTH];
  logic [c_ptr_w-1:0]   r_rd;
  logic [c_ptr_w-1:0]   r_wr;
  logic [c_cnt_w-1:0]   r_count;
  logic [31:0]          r_timer;
  logic                 r_play;
  logic                 r_busy;
  logic                 r_bad;
  logic [2:0]           r_choice;

  logic w_full;
  logic w_accept;
  logic w_is_over;
  logic w_is_clip;
  logic w_push;
  logic w_pop;

  function automatic logic [31:0] f_len(input logic [2:0] id);
    case (id)
      3'd2:    f_len = 32'(LEN_PLACE - 1);
      3'd3:    f_len = 32'(LEN_TRAV - 1);
      3'd4:    f_len = 32'(LEN_MOVE - 1);
      default: f_len = 32'(LEN_CHOMP - 1);
    endcase
  endfunction

  // GameOver is always admissible, even against a full queue.
  assign w_full          = (r_count == c_full);
  assign w_is_over       = (bus.event_id == 3'd5);
  assign w_is_clip       = (bus.event_id >= 3'd1) && (bus.event_id <= 3'd4);
  assign bus.event_ready = !rst && !bus.stop && (!w_full || w_is_over);
  assign w_accept        = bus.event_valid && bus.event_ready;
  assign w_push          = w_accept && w_is_clip;
  assign w_pop           = (r_state == ST_IDLE) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rd     <= '0;
      r_wr     <= '0;
      r_count  <= '0;
      r_timer  <= '0;
      r_play   <= 1'b0;
      r_busy   <= 1'b0;
      r_bad    <= 1'b0;
      r_choice <= 3'd0;
    end else begin
      r_play <= 1'b0;
      r_bad  <= w_accept && !w_is_over && !w_is_clip;
      if (bus.stop) begin
        r_rd     <= '0;
        r_wr     <= '0;
        r_count  <= '0;
        r_timer  <= '0;
        r_choice <= 3'd0;
        r_busy   <= 1'b0;
        r_state  <= ST_IDLE;
      end else if (w_accept && w_is_over) begin
        r_rd     <= '0;
        r_wr     <= '0;
        r_count  <= '0;
        r_timer  <= 32'(LEN_OVER - 1);
        r_choice <= 3'd5;
        r_play   <= 1'b1;
        r_busy   <= 1'b1;
        r_state  <= ST_PLAYING;
      end else begin
        if (w_push) begin
          r_mem[r_wr] <= bus.event_id;
          r_wr        <= r_wr + c_ptr_w'(1);
        end
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        case (r_state)
          ST_IDLE: begin
            if (w_pop) begin
              r_choice <= r_mem[r_rd];
              r_timer  <= f_len(r_mem[r_rd]);
              r_rd     <= r_rd + c_ptr_w'(1);
              r_play   <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= ST_PLAYING;
            end
          end
          default: begin
            if (r_timer == 32'd0) begin
              r_choice <= 3'd0;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_timer <= r_timer - 32'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.play        = r_play;
  assign bus.soundchoice = r_choice;
  assign bus.busy        = r_busy;
  assign bus.queue_count = r_count;
  assign bus.bad_event   = r_bad;

endmodule

`default_nettype wire

// File: tb/tb_sound_event_sequencer.sv
//==============================================================================
// Module      : tb_sound_event_sequencer
// Description : Directed self-checking bench for sound_event_sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sound_event_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sound_event_sequencer_if #(.QDEPTH(4)) bus_if ();

  sound_event_sequencer #(
    .QDEPTH(4), .LEN_CHOMP(10), .LEN_PLACE(12),
    .LEN_TRAV(14), .LEN_MOVE(16), .LEN_OVER(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts the cycles the current clip stays selected, then expects silence.
  task automatic run_clip(input string tag, input logic [2:0] ch, input int seen, input int len);
    int n;
    n = seen;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus_if.soundchoice !== ch) break;
      n++;
    end
    chk({tag, "_len"}, n, len);
    chk({tag, "_silent"}, {29'd0, bus_if.soundchoice}, 32'd0);
  endtask

  task automatic expect_next(input string tag, input logic [2:0] ch);
    for (int k = 0; k < 100; k++) begin
      if (bus_if.soundchoice !== 3'd0) break;
      tick();
    end
    chk(tag, {29'd0, bus_if.soundchoice}, {29'd0, ch});
    for (int k = 0; k < 100; k++) begin
      if (bus_if.soundchoice === 3'd0) break;
      tick();
    end
  endtask

  task automatic send(input logic [2:0] id);
    bus_if.event_valid = 1'b1;
    bus_if.event_id    = id;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.event_valid = 1'b0;
    bus_if.event_id    = 3'd0;
    bus_if.stop        = 1'b0;
    tick();
    tick();
    chk("rst_play",  {31'd0, bus_if.play}, 32'd0);
    chk("rst_choice", {29'd0, bus_if.soundchoice}, 32'd0);
    chk("rst_busy",  {31'd0, bus_if.busy}, 32'd0);
    chk("rst_count", {29'd0, bus_if.queue_count}, 32'd0);
    chk("rst_bad",   {31'd0, bus_if.bad_event}, 32'd0);
    chk("rst_ready", {31'd0, bus_if.event_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus_if.event_ready}, 32'd1);

    // Single chomp: queued at E0, audible from E1 for 10 cycles.
    send(3'd1);
    bus_if.event_valid = 1'b0;
    chk("t1_e0_count", {29'd0, bus_if.queue_count}, 32'd1);
    chk("t1_e0_choice", {29'd0, bus_if.soundchoice}, 32'd0);
    tick();
    chk("t1_e1_play", {31'd0, bus_if.play}, 32'd1);
    chk("t1_e1_choice", {29'd0, bus_if.soundchoice}, 32'd1);
    chk("t1_e1_busy", {31'd0, bus_if.busy}, 32'd1);
    chk("t1_e1_count", {29'd0, bus_if.queue_count}, 32'd0);
    tick();
    chk("t1_play_once", {31'd0, bus_if.play}, 32'd0);
    run_clip("t1", 3'd1, 2, 10);
    chk("t1_busy_end", {31'd0, bus_if.busy}, 32'd0);

    // Back-to-back 2,3,4 with one silent cycle between clips.
    send(3'd2);
    send(3'd3);
    chk("t2_push_pop_count", {29'd0, bus_if.queue_count}, 32'd1);
    chk("t2_c2_play", {31'd0, bus_if.play}, 32'd1);
    chk("t2_c2_choice", {29'd0, bus_if.soundchoice}, 32'd2);
    send(3'd4);
    bus_if.event_valid = 1'b0;
    chk("t2_count2", {29'd0, bus_if.queue_count}, 32'd2);
    run_clip("t2_c2", 3'd2, 2, 12);
    tick();
    chk("t2_c3_play", {31'd0, bus_if.play}, 32'd1);
    chk("t2_c3_choice", {29'd0, bus_if.soundchoice}, 32'd3);
    run_clip("t2_c3", 3'd3, 1, 14);
    tick();
    chk("t2_c4_choice", {29'd0, bus_if.soundchoice}, 32'd4);
    run_clip("t2_c4", 3'd4, 1, 16);

    // Full queue backpressure while clip 1 plays.
    send(3'd1);
    chk("t3_e0_count", {29'd0, bus_if.queue_count}, 32'd1);
    send(3'd2);
    chk("t3_e1_count", {29'd0, bus_if.queue_count}, 32'd1);
    send(3'd3);
    send(3'd4);
    send(3'd2);
    bus_if.event_valid = 1'b0;
    chk("t3_full_count", {29'd0, bus_if.queue_count}, 32'd4);
    bus_if.event_id = 3'd5;
    #1;
    chk("t3_full_ready_over", {31'd0, bus_if.event_ready}, 32'd1);
    bus_if.event_id    = 3'd1;
    bus_if.event_valid = 1'b1;
    #1;
    chk("t3_full_ready", {31'd0, bus_if.event_ready}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_if.event_ready === 1'b1) break;
    end
    chk("t3_drain_count", {29'd0, bus_if.queue_count}, 32'd3);
    tick();
    bus_if.event_valid = 1'b0;
    chk("t3_accept_count", {29'd0, bus_if.queue_count}, 32'd4);
    expect_next("t3_order0", 3'd2);
    expect_next("t3_order1", 3'd3);
    expect_next("t3_order2", 3'd4);
    expect_next("t3_order3", 3'd2);
    expect_next("t3_order4", 3'd1);
    chk("t3_empty", {29'd0, bus_if.queue_count}, 32'd0);
    tick();
    tick();
    tick();
    chk("t3_no_double", {29'd0, bus_if.soundchoice}, 32'd0);

    // GameOver mid clip 3 with two queued, then GameOver restart.
    send(3'd3);
    send(3'd1);
    send(3'd2);
    bus_if.event_valid = 1'b0;
    tick();
    tick();
    chk("t4_pre_count", {29'd0, bus_if.queue_count}, 32'd2);
    chk("t4_pre_choice", {29'd0, bus_if.soundchoice}, 32'd3);
    send(3'd5);
    bus_if.event_valid = 1'b0;
    chk("t4_over_choice", {29'd0, bus_if.soundchoice}, 32'd5);
    chk("t4_over_play", {31'd0, bus_if.play}, 32'd1);
    chk("t4_over_count", {29'd0, bus_if.queue_count}, 32'd0);
    tick();
    tick();
    tick();
    send(3'd5);
    bus_if.event_valid = 1'b0;
    chk("t4_restart_play", {31'd0, bus_if.play}, 32'd1);
    run_clip("t4_over", 3'd5, 1, 20);
    tick();
    tick();
    chk("t4_flushed", {29'd0, bus_if.soundchoice}, 32'd0);

    // stop mid clip with three queued and a pending event.
    send(3'd4);
    send(3'd1);
    send(3'd1);
    send(3'd1);
    chk("t5_pre_count", {29'd0, bus_if.queue_count}, 32'd3);
    bus_if.event_id = 3'd2;
    bus_if.stop     = 1'b1;
    #1;
    chk("t5_stop_ready", {31'd0, bus_if.event_ready}, 32'd0);
    tick();
    bus_if.stop        = 1'b0;
    bus_if.event_valid = 1'b0;
    chk("t5_choice", {29'd0, bus_if.soundchoice}, 32'd0);
    chk("t5_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("t5_count", {29'd0, bus_if.queue_count}, 32'd0);
    tick();
    tick();
    chk("t5_not_taken", {29'd0, bus_if.soundchoice}, 32'd0);

    // Invalid id, then reset mid clip.
    send(3'd1);
    send(3'd2);
    send(3'd7);
    bus_if.event_valid = 1'b0;
    chk("t6_bad", {31'd0, bus_if.bad_event}, 32'd1);
    chk("t6_bad_count", {29'd0, bus_if.queue_count}, 32'd1);
    tick();
    chk("t6_bad_pulse", {31'd0, bus_if.bad_event}, 32'd0);
    chk("t6_mid_choice", {29'd0, bus_if.soundchoice}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_choice", {29'd0, bus_if.soundchoice}, 32'd0);
    chk("t6_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("t6_rst_count", {29'd0, bus_if.queue_count}, 32'd0);
    tick();
    tick();
    chk("t6_rst_quiet", {29'd0, bus_if.soundchoice}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
